// File: rtl/gray_counter_ctrl_if.sv
// Control/status bundle for gray_counter_ctrl.
// Optional bin_out signal is present only when GRAY_BIN_OUT_EN is defined.
interface gray_counter_ctrl_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic         stop;
  logic         step;
  logic         clear;
  logic         up_dn;
  logic [1:0]   rate_sel;
  logic [N-1:0] leds;
  logic         running;
  logic         wrap;

`ifdef GRAY_BIN_OUT_EN
  logic [N-1:0] bin_out;

  modport master (
    output start, stop, step, clear, up_dn, rate_sel,
    input  leds, running, wrap, bin_out
  );
  modport slave (
    input  start, stop, step, clear, up_dn, rate_sel,
    output leds, running, wrap, bin_out
  );
`else
  modport master (
    output start, stop, step, clear, up_dn, rate_sel,
    input  leds, running, wrap
  );
  modport slave (
    input  start, stop, step, clear, up_dn, rate_sel,
    output leds, running, wrap
  );
`endif
endinterface

// File: rtl/gray_counter_ctrl.sv
// Gray-code LED counter with prescaler, run/stop/step FSM, direction and rate select.
// Define GRAY_BIN_OUT_EN to expose the registered binary count on bus.bin_out.
module gray_counter_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned DISTANCE = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  gray_counter_ctrl_if.slave bus
);
  localparam int unsigned  PW      = $clog2(DISTANCE);
  localparam logic [N-1:0] BIN_MAX = {N{1'b1}};
  // Prescaler reset value is never observed: STOPPED freezes it and start reloads it.
  localparam logic [PW-1:0] PSC_RST = PW'(DISTANCE - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  bin, bin_nxt;
  logic [N-1:0]  leds_q, leds_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic          wrap_q, wrap_nxt;
  logic          running_q;
  logic [PW-1:0] reload_c;
  logic          tick_c;
  logic          advance_c;

  // State register and all output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= STOPPED;
      bin       <= '0;
      leds_q    <= '0;
      psc       <= PSC_RST;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin       <= bin_nxt;
      leds_q    <= leds_nxt;
      psc       <= psc_nxt;
      wrap_q    <= wrap_nxt;
      running_q <= (state_nxt == RUNNING);
    end
  end

  // Next-state, prescaler and count; priority clear > stop > start > advance.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    psc_nxt   = psc;
    wrap_nxt  = 1'b0;
    advance_c = 1'b0;
    reload_c  = PW'((DISTANCE >> bus.rate_sel) - 1);
    tick_c    = (state == RUNNING) && (psc == '0);

    if (bus.clear) begin
      bin_nxt = '0;
      psc_nxt = reload_c;
    end else if (bus.stop) begin
      state_nxt = STOPPED;
      psc_nxt   = reload_c;
    end else if (bus.start && (state == STOPPED)) begin
      state_nxt = RUNNING;
      psc_nxt   = reload_c;
    end else begin
      if (state == RUNNING) begin
        psc_nxt = tick_c ? reload_c : psc - PW'(1);
      end
      advance_c = tick_c || ((state == STOPPED) && bus.step);
    end

    if (advance_c) begin
      if (bus.up_dn) begin
        bin_nxt  = bin + N'(1);
        wrap_nxt = (bin == BIN_MAX);
      end else begin
        bin_nxt  = bin - N'(1);
        wrap_nxt = (bin == '0);
      end
    end

    leds_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  assign bus.leds    = leds_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;
`ifdef GRAY_BIN_OUT_EN
  assign bus.bin_out = bin;
`endif
endmodule
